cmac_rx_pkt_filter: RTL and testbench
=====================================

// Module: cmac_rx_pkt_filter
// PURPOSE
//  Receive-side packet buffer between a CMAC RX AXIS port and its RX CDC FIFO; counterpart of the TX packetization FIFO.
//  Stores CMAC RX beats (no backpressure possible) and commits a packet only on an error-free tlast.
//  Drops errored (tuser=1) and overflowing packets whole, so downstream only ever sees complete, good packets.
// PARAMETERS
//  DEPTH   256  buffer depth in 512-bit beats; power of 2, >=16
//  CNT_W   32   width of statistics counters
// PORTS
//  cmac_clk         in   1    sole clock (CMAC RX domain)
//  cmac_resetn      in   1    asynchronous, active-low reset
//  rx_tdata         in   512  CMAC RX data
//  rx_tkeep         in   64   CMAC RX byte enables
//  rx_tuser         in   1    CMAC RX error flag, meaningful on tlast beat
//  rx_tlast         in   1    last beat of packet
//  rx_tvalid        in   1    beat valid (no tready: CMAC cannot be stalled)
//  m_tdata          out  512  filtered stream to RX CDC FIFO
//  m_tkeep          out  64
//  m_tuser          out  1    constant 0
//  m_tlast          out  1
//  m_tvalid         out  1
//  m_tready         in   1
//  pkt_count        out  CNT_W  good packets committed, saturating
//  drop_err_count   out  CNT_W  packets dropped for tuser=1, saturating
//  drop_ovf_count   out  CNT_W  packets dropped for buffer overflow, saturating
//  overflow         out  1    one-cycle pulse on each overflow drop
// BEHAVIOUR
//  Reset (async assert, sync release): wr_ptr=commit_ptr=rd_ptr=0, state ACCEPT, m_tvalid=0, counters=0, overflow=0.
//  Pointers ADDR_W+1 bits (ADDR_W=log2 DEPTH), wrap naturally; occupancy = wr_ptr - rd_ptr; full when occupancy==DEPTH.
//  Write FSM, one transition per rx_tvalid beat:
//   ACCEPT, not full, !tlast:  write {tlast,tkeep,tdata} at wr_ptr, wr_ptr++.
//   ACCEPT, not full, tlast, tuser=0: write, commit_ptr<=wr_ptr+1, wr_ptr++, pkt_count++.
//   ACCEPT, not full, tlast, tuser=1: no write, wr_ptr<=commit_ptr, drop_err_count++.
//   ACCEPT, full: wr_ptr<=commit_ptr, drop_ovf_count++, overflow=1; -> DISCARD unless this beat is tlast (stay ACCEPT).
//   DISCARD: ignore beats; on tlast -> ACCEPT. No counter changes.
//  Packet longer than DEPTH beats always drops as overflow. tuser on non-last beats ignored.
//  Full uses current registered rd_ptr; a same-cycle pop does not free space (conservative).
//  Read side: data available while rd_ptr != commit_ptr; 1-cycle sync RAM read into 2-entry output stage; full throughput (1 beat/clk) under continuous m_tready.
//  Latency: good tlast written at cycle N -> commit visible N+1 -> first beat of a 1-beat packet on m_tvalid at N+3 (buffer previously empty).
//  AXIS rules: m_tvalid, once high, holds with stable data until m_tready; no uncommitted beat ever reaches the output.
//  Rollback never touches entries <= commit_ptr; read side unaffected by drops.
//  Simultaneous commit and pop: both take effect; empty/full recomputed next cycle.
//  Reset mid-operation: all state cleared immediately; buffered and in-flight packets lost; upstream releases cmac_resetn only with CMAC RX idle (post-reset first beat = start of packet).
//  Counters saturate at all-ones.
// STRUCTURE
//  Shared package cmac_pkg: DATA_W=512, KEEP_W=64, BEAT_W=DATA_W+KEEP_W+1 (tlast packed in MSB).
//  One sub-module: cmac_rx_pkt_ram -- simple dual-port RAM, DEPTH x BEAT_W, registered read, write-first not required.
//  Write FSM, pointers, counters and output skid stage live in this module.
// TESTING
//  4-beat good pkt (tuser=0), m_tready=1 -> 4 beats out, tkeep/tlast intact, pkt_count=1, first m_tvalid 3 clks after tlast.
//  3-beat pkt with tuser=1 on tlast, then 2-beat good -> only 2-beat pkt out, drop_err_count=1, pkt_count=1.
//  m_tready=0, DEPTH=16, send 10-beat then 10-beat -> 2nd dropped, overflow pulses once, drop_ovf_count=1; release m_tready -> only 1st 10-beat pkt out.
//  DEPTH=16, 20-beat pkt with buffer empty -> dropped as overflow; following 1-beat pkt delivered.
//  Back-to-back 1-beat good pkts for 1000 clks, m_tready random 50% -> in-order, no loss until full, pkt_count+drop_ovf_count=1000.
//  Assert cmac_resetn mid-packet with 5 beats buffered -> m_tvalid=0 and counters=0 that cycle; next full pkt after release delivered intact.

Source files
------------

// File: rtl/cmac_pkg.sv
// Shared CMAC beat types and widths.
// Beat layout: tlast in the MSB, then tkeep, then tdata.
package cmac_pkg;

  localparam int DATA_W = 512;
  localparam int KEEP_W = 64;
  localparam int BEAT_W = DATA_W + KEEP_W + 1;

  typedef enum logic {
    ST_ACCEPT  = 1'b0,
    ST_DISCARD = 1'b1
  } wr_state_e;

  typedef struct packed {
    logic              last;
    logic [KEEP_W-1:0] keep;
    logic [DATA_W-1:0] data;
  } beat_t;

endpackage

// File: rtl/cmac_rx_pkt_ram.sv
// Simple dual-port beat store for the RX packet filter.
// One write port, one registered read port.
module cmac_rx_pkt_ram
  import cmac_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  beat_t             i_wr_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output beat_t             o_rd_data
);

  beat_t r_mem [DEPTH];
  beat_t r_rd_data;

  // write port
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/cmac_rx_pkt_filter.sv
// CMAC RX packet filter: buffers beats, commits good packets,
// drops errored or overflowing packets whole.
module cmac_rx_pkt_filter
  import cmac_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int CNT_W = 32
) (
  input  logic              cmac_clk,
  input  logic              cmac_resetn,
  input  logic [DATA_W-1:0] rx_tdata,
  input  logic [KEEP_W-1:0] rx_tkeep,
  input  logic              rx_tuser,
  input  logic              rx_tlast,
  input  logic              rx_tvalid,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic              m_tuser,
  output logic              m_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  drop_err_count,
  output logic [CNT_W-1:0]  drop_ovf_count,
  output logic              overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LP_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LP_ONE  = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0] LP_CNT1 = CNT_W'(1);

  wr_state_e       r_state;
  wr_state_e       w_state_nxt;
  logic [ADDR_W:0] r_wr_ptr;
  logic [ADDR_W:0] r_commit_ptr;
  logic [ADDR_W:0] r_rd_ptr;
  logic [ADDR_W:0] w_wr_ptr_nxt;
  logic [ADDR_W:0] w_commit_nxt;
  logic            w_full;
  logic            w_wr_en;
  logic            w_inc_pkt;
  logic            w_inc_err;
  logic            w_inc_ovf;

  logic [CNT_W-1:0] r_pkt_count;
  logic [CNT_W-1:0] r_err_count;
  logic [CNT_W-1:0] r_ovf_count;
  logic             r_overflow;

  beat_t       w_wr_data;
  beat_t       w_rd_data;
  logic        w_avail;
  logic        w_rd_en;
  logic        w_pop;
  logic [2:0]  w_load;
  logic        r_rd_vld;
  logic [1:0]  r_ob_cnt;
  beat_t       r_ob0;
  beat_t       r_ob1;

  // Full is judged against the registered read pointer only.
  assign w_full = (r_wr_ptr - r_rd_ptr) == LP_FULL;

  assign w_wr_data = '{
    last: rx_tlast,
    keep: rx_tkeep,
    data: rx_tdata
  };

  // write FSM next-state, pointer updates and counter events
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_commit_nxt = r_commit_ptr;
    w_wr_en      = 1'b0;
    w_inc_pkt    = 1'b0;
    w_inc_err    = 1'b0;
    w_inc_ovf    = 1'b0;
    if (rx_tvalid) begin
      unique case (r_state)
        ST_ACCEPT: begin
          if (w_full) begin
            w_wr_ptr_nxt = r_commit_ptr;
            w_inc_ovf    = 1'b1;
            if (!rx_tlast) begin
              w_state_nxt = ST_DISCARD;
            end
          end else if (!rx_tlast) begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + LP_ONE;
          end else if (!rx_tuser) begin
            w_wr_en      = 1'b1;
            w_wr_ptr_nxt = r_wr_ptr + LP_ONE;
            w_commit_nxt = r_wr_ptr + LP_ONE;
            w_inc_pkt    = 1'b1;
          end else begin
            w_wr_ptr_nxt = r_commit_ptr;
            w_inc_err    = 1'b1;
          end
        end
        ST_DISCARD: begin
          if (rx_tlast) begin
            w_state_nxt = ST_ACCEPT;
          end
        end
        default: begin
          w_state_nxt = ST_ACCEPT;
        end
      endcase
    end
  end

  // write-side state, pointers and overflow pulse
  always_ff @(posedge cmac_clk or negedge cmac_resetn) begin
    if (!cmac_resetn) begin
      r_state      <= ST_ACCEPT;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_commit_ptr <= w_commit_nxt;
      r_overflow   <= w_inc_ovf;
    end
  end

  // saturating statistics counters
  always_ff @(posedge cmac_clk or negedge cmac_resetn) begin
    if (!cmac_resetn) begin
      r_pkt_count <= '0;
      r_err_count <= '0;
      r_ovf_count <= '0;
    end else begin
      if (w_inc_pkt && !(&r_pkt_count)) begin
        r_pkt_count <= r_pkt_count + LP_CNT1;
      end
      if (w_inc_err && !(&r_err_count)) begin
        r_err_count <= r_err_count + LP_CNT1;
      end
      if (w_inc_ovf && !(&r_ovf_count)) begin
        r_ovf_count <= r_ovf_count + LP_CNT1;
      end
    end
  end

  cmac_rx_pkt_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk      (cmac_clk),
    .i_wr_en  (w_wr_en),
    .i_wr_addr(r_wr_ptr[ADDR_W-1:0]),
    .i_wr_data(w_wr_data),
    .i_rd_en  (w_rd_en),
    .i_rd_addr(r_rd_ptr[ADDR_W-1:0]),
    .o_rd_data(w_rd_data)
  );

  // Issue a read only if the output stage will have room when
  // it lands; one read in flight plus one held keeps 1 beat/clk.
  assign w_avail = r_rd_ptr != r_commit_ptr;
  assign w_pop   = (r_ob_cnt != 2'd0) && m_tready;
  assign w_load  = 3'(r_ob_cnt) + 3'(r_rd_vld) - 3'(w_pop);
  assign w_rd_en = w_avail && (w_load <= 3'd1);

  // read pointer and read-in-flight flag
  always_ff @(posedge cmac_clk or negedge cmac_resetn) begin
    if (!cmac_resetn) begin
      r_rd_ptr <= '0;
      r_rd_vld <= 1'b0;
    end else begin
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + LP_ONE;
      end
      r_rd_vld <= w_rd_en;
    end
  end

  // two-entry output stage, head in r_ob0
  always_ff @(posedge cmac_clk or negedge cmac_resetn) begin
    if (!cmac_resetn) begin
      r_ob_cnt <= 2'd0;
      r_ob0    <= '0;
      r_ob1    <= '0;
    end else begin
      unique case ({r_rd_vld, w_pop})
        2'b10: begin
          if (r_ob_cnt == 2'd0) begin
            r_ob0 <= w_rd_data;
          end else begin
            r_ob1 <= w_rd_data;
          end
          r_ob_cnt <= r_ob_cnt + 2'd1;
        end
        2'b01: begin
          r_ob0    <= r_ob1;
          r_ob_cnt <= r_ob_cnt - 2'd1;
        end
        2'b11: begin
          if (r_ob_cnt == 2'd1) begin
            r_ob0 <= w_rd_data;
          end else begin
            r_ob0 <= r_ob1;
            r_ob1 <= w_rd_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign m_tvalid       = r_ob_cnt != 2'd0;
  assign m_tdata        = r_ob0.data;
  assign m_tkeep        = r_ob0.keep;
  assign m_tlast        = r_ob0.last;
  assign m_tuser        = 1'b0;
  assign pkt_count      = r_pkt_count;
  assign drop_err_count = r_err_count;
  assign drop_ovf_count = r_ovf_count;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_cmac_rx_pkt_filter.sv
// Self-checking bench for cmac_rx_pkt_filter (DEPTH=16).
// Scoreboard of expected output beats, directed steps.
module tb_cmac_rx_pkt_filter;
  import cmac_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;

  logic              cmac_clk = 1'b0;
  logic              cmac_resetn = 1'b0;
  logic [DATA_W-1:0] rx_tdata = '0;
  logic [KEEP_W-1:0] rx_tkeep = '0;
  logic              rx_tuser = 1'b0;
  logic              rx_tlast = 1'b0;
  logic              rx_tvalid = 1'b0;
  logic [DATA_W-1:0] m_tdata;
  logic [KEEP_W-1:0] m_tkeep;
  logic              m_tuser;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready = 1'b1;
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  drop_err_count;
  logic [CNT_W-1:0]  drop_ovf_count;
  logic              overflow;

  always #5 cmac_clk = ~cmac_clk;

  cmac_rx_pkt_filter #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) dut (
    .cmac_clk      (cmac_clk),
    .cmac_resetn   (cmac_resetn),
    .rx_tdata      (rx_tdata),
    .rx_tkeep      (rx_tkeep),
    .rx_tuser      (rx_tuser),
    .rx_tlast      (rx_tlast),
    .rx_tvalid     (rx_tvalid),
    .m_tdata       (m_tdata),
    .m_tkeep       (m_tkeep),
    .m_tuser       (m_tuser),
    .m_tlast       (m_tlast),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .pkt_count     (pkt_count),
    .drop_err_count(drop_err_count),
    .drop_ovf_count(drop_ovf_count),
    .overflow      (overflow)
  );

  int checks = 0;
  int failures = 0;
  logic [BEAT_W-1:0] sb [$];
  bit   skip_mode = 1'b0;
  int   skipped = 0;
  int   received = 0;
  int   ovf_pulses = 0;
  bit   stall_prev = 1'b0;
  logic [BEAT_W-1:0] prev_beat = '0;
  logic [BEAT_W-1:0] cur;
  logic [BEAT_W-1:0] exp_b;

  task automatic chk(input string tag,
                     input logic [BEAT_W-1:0] obs,
                     input logic [BEAT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] mk_beat(
    input int id, input int idx, input bit last);
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    logic [15:0] hi;
    logic [15:0] lo;
    hi = id[15:0];
    lo = idx[15:0];
    d = {16{hi, lo}};
    k = last ? ({KEEP_W{1'b1}} >> (id % 61 + 1)) : {KEEP_W{1'b1}};
    return {last, k, d};
  endfunction

  // tuser is driven high on non-last beats: it must be ignored there
  task automatic send_pkt(input int id, input int len,
                          input bit user, input bit good);
    logic [BEAT_W-1:0] b;
    for (int i = 0; i < len; i++) begin
      b = mk_beat(id, i, i == len - 1);
      if (good) sb.push_back(b);
      {rx_tlast, rx_tkeep, rx_tdata} = b;
      rx_tuser  = (i == len - 1) ? user : 1'b1;
      rx_tvalid = 1'b1;
      @(posedge cmac_clk);
      #1;
    end
    rx_tvalid = 1'b0;
    rx_tuser  = 1'b0;
    rx_tlast  = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(posedge cmac_clk);
      n++;
    end
    #1;
    chk_n(tag, 32'(sb.size()), 0);
    repeat (4) @(posedge cmac_clk);
    #1;
  endtask

  task automatic do_reset();
    cmac_resetn = 1'b0;
    sb.delete();
    repeat (3) @(posedge cmac_clk);
    #1;
    cmac_resetn = 1'b1;
    @(posedge cmac_clk);
    #1;
  endtask

  // output monitor: scoreboard compare and AXIS hold rule
  always @(negedge cmac_clk) begin
    cur = {m_tlast, m_tkeep, m_tdata};
    if (!cmac_resetn) begin
      stall_prev = 1'b0;
    end else begin
      if (overflow) ovf_pulses++;
      if (stall_prev) begin
        chk_n("hold_valid", 32'(m_tvalid), 1);
        chk("hold_data", cur, prev_beat);
      end
      if (m_tvalid && m_tready) begin
        chk_n("m_tuser", 32'(m_tuser), 0);
        if (skip_mode) begin
          while (sb.size() > 0 && sb[0] !== cur) begin
            void'(sb.pop_front());
            skipped++;
          end
        end
        exp_b = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk("out_beat", cur, exp_b);
        received++;
      end
      stall_prev = m_tvalid && !m_tready;
      prev_beat  = cur;
    end
  end

  initial begin
    int lat;

    // reset state
    do_reset();
    chk_n("rst_tvalid", 32'(m_tvalid), 0);
    chk_n("rst_pkt", pkt_count, 0);
    chk_n("rst_err", drop_err_count, 0);
    chk_n("rst_ovf", drop_ovf_count, 0);
    chk_n("rst_ovf_pulse", 32'(overflow), 0);

    // 4-beat good packet, latency from tlast
    m_tready = 1'b1;
    send_pkt(1, 4, 1'b0, 1'b1);
    lat = 0;
    do begin
      @(negedge cmac_clk);
      lat++;
    end while (!m_tvalid && lat < 20);
    chk_n("latency", lat, 3);
    wait_drain("drain_t1", 50);
    chk_n("t1_pkt", pkt_count, 1);
    chk_n("t1_err", drop_err_count, 0);

    // errored packet then good packet
    do_reset();
    send_pkt(2, 3, 1'b1, 1'b0);
    send_pkt(3, 2, 1'b0, 1'b1);
    wait_drain("drain_t2", 50);
    chk_n("t2_err", drop_err_count, 1);
    chk_n("t2_pkt", pkt_count, 1);

    // stalled output, second 10-beat packet overflows
    do_reset();
    m_tready = 1'b0;
    ovf_pulses = 0;
    send_pkt(4, 10, 1'b0, 1'b1);
    send_pkt(5, 10, 1'b0, 1'b0);
    repeat (5) @(posedge cmac_clk);
    #1;
    chk_n("t3_pulses", ovf_pulses, 1);
    chk_n("t3_ovf", drop_ovf_count, 1);
    chk_n("t3_pkt", pkt_count, 1);
    chk_n("t3_stall_valid", 32'(m_tvalid), 1);
    m_tready = 1'b1;
    wait_drain("drain_t3", 60);

    // packet longer than the buffer, then 1-beat packet
    do_reset();
    ovf_pulses = 0;
    send_pkt(6, 20, 1'b0, 1'b0);
    send_pkt(7, 1, 1'b0, 1'b1);
    wait_drain("drain_t4", 50);
    chk_n("t4_ovf", drop_ovf_count, 1);
    chk_n("t4_pkt", pkt_count, 1);
    chk_n("t4_pulses", ovf_pulses, 1);

    // 1000 back-to-back 1-beat packets, random ready
    do_reset();
    skip_mode = 1'b1;
    skipped = 0;
    received = 0;
    for (int i = 0; i < 1000; i++) begin
      m_tready = 1'($urandom_range(0, 1));
      send_pkt(1000 + i, 1, 1'b0, 1'b1);
    end
    m_tready = 1'b1;
    repeat (60) @(posedge cmac_clk);
    #1;
    skipped += sb.size();
    sb.delete();
    skip_mode = 1'b0;
    chk_n("t5_total", pkt_count + drop_ovf_count, 1000);
    chk_n("t5_received", received, pkt_count);
    chk_n("t5_skipped", skipped, drop_ovf_count);
    chk_n("t5_err", drop_err_count, 0);

    // reset mid-packet with beats buffered
    do_reset();
    m_tready = 1'b0;
    send_pkt(8, 3, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      {rx_tlast, rx_tkeep, rx_tdata} = mk_beat(9, i, 1'b0);
      rx_tvalid = 1'b1;
      @(posedge cmac_clk);
      #1;
    end
    rx_tvalid = 1'b0;
    repeat (4) @(posedge cmac_clk);
    #1;
    chk_n("t6_pre_valid", 32'(m_tvalid), 1);
    chk_n("t6_pre_pkt", pkt_count, 1);
    #2;
    cmac_resetn = 1'b0;
    sb.delete();
    #1;
    chk_n("t6_rst_valid", 32'(m_tvalid), 0);
    chk_n("t6_rst_pkt", pkt_count, 0);
    chk_n("t6_rst_ovf", drop_ovf_count, 0);
    chk_n("t6_rst_err", drop_err_count, 0);
    repeat (2) @(posedge cmac_clk);
    #1;
    cmac_resetn = 1'b1;
    m_tready = 1'b1;
    @(posedge cmac_clk);
    #1;
    send_pkt(10, 4, 1'b0, 1'b1);
    wait_drain("drain_t6", 50);
    chk_n("t6_pkt", pkt_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
